// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Scan scheduler for a 3-digit multiplexed 7-segment display.
// Each digit gets a slot of SCAN_DIV clocks. The first BLANK_CYC clocks of a
// slot are blank to avoid ghosting, and the digit is shown for the rest of the
// slot. A BCD value loaded through load/load_ack sits in a pending register and
// is moved into the displayed (shadow) register only at a frame boundary or
// while idle. A frame therefore never mixes digits from two different values.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   enable     - scanning enable; low forces IDLE
//   bcd_in     - {hundreds, tens, units} BCD value to capture
//   load       - single-cycle capture request for bcd_in
//   lz_blank   - leading-zero suppression enable
//   load_ack   - pulses when a captured value becomes the displayed value
//   frame_done - pulses after the last hundreds-digit cycle of a frame
//   display    - one-hot digit enable (001 units, 010 tens, 100 hundreds)
//   digit_disp - active-high segments {a,b,c,d,e,f,g}
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 33333,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        lz_blank,
  output logic        load_ack,
  output logic        frame_done,
  output logic [2:0]  display,
  output logic [6:0]  digit_disp
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SHOW_START = CW'(BLANK_CYC);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state_q, state_d;
  logic [1:0]      digitIdx_q, digitIdx_d;
  logic [CW-1:0]   slotCnt_q, slotCnt_d;
  logic            pendValid_q, pendValid_d;
  logic [11:0]     pendData_q, pendData_d;
  logic [11:0]     shadow_q, shadow_d;
  logic            loadAck_q, loadAck_d;
  logic            frameDone_q, frameDone_d;
  logic [2:0]      display_q, display_d;
  logic [6:0]      segs_q, segs_d;
  logic            frameEnd;
  logic            transfer;
  logic [3:0]      selDigit;
  logic            suppress;

  function automatic logic [6:0] decodeSeg(input logic [3:0] digit);
    case (digit)
      4'd0:    decodeSeg = 7'b1111110;
      4'd1:    decodeSeg = 7'b0110000;
      4'd2:    decodeSeg = 7'b1101101;
      4'd3:    decodeSeg = 7'b1111001;
      4'd4:    decodeSeg = 7'b0110011;
      4'd5:    decodeSeg = 7'b1011011;
      4'd6:    decodeSeg = 7'b1011111;
      4'd7:    decodeSeg = 7'b1110000;
      4'd8:    decodeSeg = 7'b1111111;
      4'd9:    decodeSeg = 7'b1111011;
      default: decodeSeg = 7'b0000000;
    endcase
  endfunction

  // Slot scheduler: one counter spans the whole slot; the blank/show split is
  // derived from where the counter sits relative to BLANK_CYC.
  always_comb begin
    state_d    = state_q;
    digitIdx_d = digitIdx_q;
    slotCnt_d  = slotCnt_q;
    frameEnd   = (state_q == SHOW) && (digitIdx_q == 2'd2) &&
                 (slotCnt_q == SLOT_LAST) && enable;
    if (!enable) begin
      state_d    = IDLE;
      digitIdx_d = 2'd0;
      slotCnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = BLANK;
          digitIdx_d = 2'd0;
          slotCnt_d  = '0;
        end
        BLANK, SHOW: begin
          if (slotCnt_q == SLOT_LAST) begin
            slotCnt_d  = '0;
            state_d    = BLANK;
            digitIdx_d = (digitIdx_q == 2'd2) ? 2'd0 : digitIdx_q + 2'd1;
          end else begin
            slotCnt_d = slotCnt_q + 1'b1;
            state_d   = (slotCnt_d >= SHOW_START) ? SHOW : BLANK;
          end
        end
        default: begin
          state_d    = IDLE;
          digitIdx_d = 2'd0;
          slotCnt_d  = '0;
        end
      endcase
    end
  end

  // Load handshake. The transfer always uses the pending value from before
  // this edge, so a coincident load stays pending for the next opportunity.
  // Blocking a transfer right after an ack keeps load_ack from ever being
  // high on two consecutive cycles while idle.
  always_comb begin
    transfer    = pendValid_q && !loadAck_q && (frameEnd || (state_q == IDLE));
    shadow_d    = transfer ? pendData_q : shadow_q;
    pendData_d  = load ? bcd_in : pendData_q;
    pendValid_d = load ? 1'b1 : (transfer ? 1'b0 : pendValid_q);
    loadAck_d   = transfer;
    frameDone_d = frameEnd;
  end

  // Output registers are computed from the next state, so the outputs line
  // up with the state that is entered on this edge.
  always_comb begin
    display_d = 3'b000;
    segs_d    = 7'b0000000;
    case (digitIdx_d)
      2'd0:    selDigit = shadow_d[3:0];
      2'd1:    selDigit = shadow_d[7:4];
      default: selDigit = shadow_d[11:8];
    endcase
    suppress = lz_blank &&
               (((digitIdx_d == 2'd2) && (shadow_d[11:8] == 4'd0)) ||
                ((digitIdx_d == 2'd1) && (shadow_d[11:4] == 8'd0)));
    if (state_d == SHOW) begin
      display_d = 3'b001 << digitIdx_d;
      segs_d    = suppress ? 7'b0000000 : decodeSeg(selDigit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      digitIdx_q  <= 2'd0;
      slotCnt_q   <= '0;
      pendValid_q <= 1'b0;
      pendData_q  <= 12'h000;
      shadow_q    <= 12'h000;
      loadAck_q   <= 1'b0;
      frameDone_q <= 1'b0;
      display_q   <= 3'b000;
      segs_q      <= 7'b0000000;
    end else begin
      state_q     <= state_d;
      digitIdx_q  <= digitIdx_d;
      slotCnt_q   <= slotCnt_d;
      pendValid_q <= pendValid_d;
      pendData_q  <= pendData_d;
      shadow_q    <= shadow_d;
      loadAck_q   <= loadAck_d;
      frameDone_q <= frameDone_d;
      display_q   <= display_d;
      segs_q      <= segs_d;
    end
  end

  assign load_ack   = loadAck_q;
  assign frame_done = frameDone_q;
  assign display    = display_q;
  assign digit_disp = segs_q;

endmodule
